// File: rtl/layer_seq_ctrl.sv
// Sequencing controller for a single-MAC fully-connected layer: loads an N-element vector,
// walks M rows of N MAC terms, and streams each row result out. Optional counters: LAYER_SEQ_CTRL_PERF_EN.
module layer_seq_ctrl #(
  parameter int M       = 4,
  parameter int N       = 5,
  parameter int MAC_LAT = 2,
  localparam int XW = (N > 1) ? $clog2(N) : 1,
  localparam int WW = (M * N > 1) ? $clog2(M * N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          x_wr_en,
  output logic [XW-1:0] x_addr,
  output logic [WW-1:0] w_addr,
  output logic          acc_clr,
  output logic          acc_en
`ifdef LAYER_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]   vec_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [XW-1:0] COL_LAST   = XW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(M - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(MAC_LAT - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_OUT
  } state_e;

  state_e        state, state_nxt;
  logic [XW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [DW-1:0] drain, drain_nxt;

  logic s_beat;
  logic m_beat;

  assign s_beat = s_valid & s_ready;
  assign m_beat = m_valid & m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_LOAD;
      col   <= '0;
      row   <= '0;
      drain <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      drain <= drain_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    drain_nxt = drain;
    case (state)
      ST_LOAD: begin
        if (s_beat) begin
          if (col == COL_LAST) begin
            col_nxt   = '0;
            row_nxt   = '0;
            state_nxt = ST_COMPUTE;
          end else begin
            col_nxt = col + XW'(1);
          end
        end
      end
      ST_COMPUTE: begin
        // One term per cycle with no stall path; the column wraps as the row completes.
        if (col == COL_LAST) begin
          col_nxt   = '0;
          drain_nxt = DRAIN_INIT;
          state_nxt = ST_DRAIN;
        end else begin
          col_nxt = col + XW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain == '0) begin
          state_nxt = ST_OUT;
        end else begin
          drain_nxt = drain - DW'(1);
        end
      end
      ST_OUT: begin
        if (m_beat) begin
          if (row == ROW_LAST) begin
            row_nxt   = '0;
            state_nxt = ST_LOAD;
          end else begin
            row_nxt   = row + RW'(1);
            state_nxt = ST_COMPUTE;
          end
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Outputs are gated by reset_n so they read 0 while reset is held, not just after the first edge.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    x_addr  = '0;
    w_addr  = '0;
    if (reset_n) begin
      case (state)
        ST_LOAD: begin
          s_ready = 1'b1;
          x_addr  = col;
        end
        ST_COMPUTE: begin
          acc_en  = 1'b1;
          acc_clr = (col == '0);
          x_addr  = col;
          w_addr  = WW'(row) * WW'(N) + WW'(col);
        end
        ST_OUT: begin
          m_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign x_wr_en = s_valid & s_ready;

`ifdef LAYER_SEQ_CTRL_PERF_EN
  logic vec_done;
  logic out_stall;

  assign vec_done  = m_beat && (row == ROW_LAST);
  assign out_stall = m_valid && !m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (vec_done && (vec_cnt != '1)) begin
        vec_cnt <= vec_cnt + 32'd1;
      end
      if (out_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl: default geometry plus an M=1,N=1,MAC_LAT=1 instance.
// Perf counter checks are compiled only when LAYER_SEQ_CTRL_PERF_EN is defined.
module tb_layer_seq_ctrl;

  logic       clk;
  logic       reset_n;
  logic       s_valid;
  logic       m_ready;
  logic       s_ready;
  logic       m_valid;
  logic       x_wr_en;
  logic [2:0] x_addr;
  logic [4:0] w_addr;
  logic       acc_clr;
  logic       acc_en;

  logic       rst2_n;
  logic       s2_valid;
  logic       m2_ready;
  logic       s2_ready;
  logic       m2_valid;
  logic       x2_wr_en;
  logic [0:0] x2_addr;
  logic [0:0] w2_addr;
  logic       acc2_clr;
  logic       acc2_en;

`ifdef LAYER_SEQ_CTRL_PERF_EN
  logic [31:0] vec_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] vec2_cnt;
  logic [31:0] stall2_cnt;
`endif

  layer_seq_ctrl #(.M(4), .N(5), .MAC_LAT(2)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .x_wr_en   (x_wr_en),
    .x_addr    (x_addr),
    .w_addr    (w_addr),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en)
`ifdef LAYER_SEQ_CTRL_PERF_EN
    ,
    .vec_cnt   (vec_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  layer_seq_ctrl #(.M(1), .N(1), .MAC_LAT(1)) u_small (
    .clk       (clk),
    .reset_n   (rst2_n),
    .s_valid   (s2_valid),
    .s_ready   (s2_ready),
    .m_valid   (m2_valid),
    .m_ready   (m2_ready),
    .x_wr_en   (x2_wr_en),
    .x_addr    (x2_addr),
    .w_addr    (w2_addr),
    .acc_clr   (acc2_clr),
    .acc_en    (acc2_en)
`ifdef LAYER_SEQ_CTRL_PERF_EN
    ,
    .vec_cnt   (vec2_cnt),
    .stall_cnt (stall2_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at a falling edge with reset just released; the current cycle is cycle 0.
  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int exp_mv[8] = '{12, 20, 28, 36, 49, 57, 65, 73};
  int cyc, wr_cnt, iss, mv_cnt, hs, vec_beats, stall, early, hs3_cyc, first_mv;
  logic issue_seen, hit;
  logic [4:0] exp5;

  initial begin
    reset_n  = 1'b0;
    s_valid  = 1'b1;
    m_ready  = 1'b1;
    rst2_n   = 1'b0;
    s2_valid = 1'b0;
    m2_ready = 1'b0;

    // Reset state: outputs low even with s_valid asserted.
    #3;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_x_wr_en", x_wr_en, 0);
    check("rst_acc_en", acc_en, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_x_addr", x_addr, 0);
    check("rst_w_addr", w_addr, 0);

    // 1: streams always ready, two back-to-back vectors.
    reset_dut();
    s_valid = 1'b1;
    m_ready = 1'b1;
    wr_cnt = 0; iss = 0; mv_cnt = 0;
    for (int c = 0; c < 74; c++) begin
      #2;
      if (x_wr_en) begin
        check("t1_x_addr", x_addr, wr_cnt % 5);
        check("t1_wr_cyc", c, (wr_cnt / 5) * 37 + (wr_cnt % 5));
        wr_cnt++;
      end
      if (acc_en) begin
        check("t1_w_addr", w_addr, iss % 20);
        check("t1_acc_clr", acc_clr, (iss % 5) == 0);
        iss++;
      end
      if (m_valid) begin
        if (mv_cnt < 8) check("t1_mv_cyc", c, exp_mv[mv_cnt]);
        mv_cnt++;
      end
      if (c == 36) check("t1_s_ready_c36", s_ready, 0);
      if (c == 37) check("t1_s_ready_c37", s_ready, 1);
      @(negedge clk);
    end
    check("t1_wr_total", wr_cnt, 10);
    check("t1_iss_total", iss, 40);
    check("t1_mv_total", mv_cnt, 8);

    // 2: random input valid, two vectors.
    reset_dut();
    m_ready = 1'b1;
    cyc = 0; hs = 0; vec_beats = 0; issue_seen = 1'b0;
    while (cyc < 600 && hs < 8) begin
      s_valid = 1'($urandom_range(0, 1));
      #2;
      if (x_wr_en) begin
        check("t2_x_addr", x_addr, vec_beats);
        vec_beats++;
      end
      if (acc_en && !issue_seen) begin
        check("t2_beats_before_compute", vec_beats, 5);
        issue_seen = 1'b1;
      end
      if (m_valid && m_ready) begin
        hs++;
        if (hs % 4 == 0) begin
          check("t2_beats_per_vec", vec_beats, 5);
          vec_beats  = 0;
          issue_seen = 1'b0;
        end
      end
      cyc++;
      @(negedge clk);
    end
    check("t2_done", hs, 8);

    // 3: downstream stalls 10 cycles on row 2.
    reset_dut();
    s_valid = 1'b1;
    cyc = 0; hs = 0; stall = 0; early = 0; hs3_cyc = -1;
    while (cyc < 200 && hs < 4) begin
      #1;
      m_ready = !(m_valid && hs == 2 && stall < 10);
      #1;
      if (!m_ready) begin
        check("t3_mv_hold", m_valid, 1);
        check("t3_acc_en_idle", acc_en, 0);
        stall++;
      end
      if (acc_en && w_addr >= 15 && hs < 3) early++;
      if (acc_en && w_addr == 15) check("t3_row3_start", cyc, hs3_cyc + 1);
      if (m_valid && m_ready) begin
        hs++;
        if (hs == 3) hs3_cyc = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    check("t3_hs3_cyc", hs3_cyc, 38);
    check("t3_stall_cycles", stall, 10);
    check("t3_early_row3", early, 0);
    check("t3_done", hs, 4);
    m_ready = 1'b1;

    // 4: reset pulsed mid-COMPUTE of row 1.
    reset_dut();
    s_valid = 1'b1;
    m_ready = 1'b1;
    cyc = 0; hit = 1'b0;
    while (cyc < 60 && !hit) begin
      #2;
      if (acc_en && w_addr == 7) hit = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    check("t4_hit_cyc", cyc, 15);
    reset_n = 1'b0;
    #1;
    check("t4_rst_s_ready", s_ready, 0);
    check("t4_rst_m_valid", m_valid, 0);
    check("t4_rst_x_wr_en", x_wr_en, 0);
    check("t4_rst_acc_en", acc_en, 0);
    check("t4_rst_acc_clr", acc_clr, 0);
    check("t4_rst_x_addr", x_addr, 0);
    check("t4_rst_w_addr", w_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mv_cnt = 0; first_mv = -1; issue_seen = 1'b0;
    for (int c = 0; c < 37; c++) begin
      #2;
      if (c == 0) begin
        check("t4_s_ready", s_ready, 1);
        check("t4_x_addr0", x_addr, 0);
      end
      if (acc_en && !issue_seen) begin
        check("t4_first_w_addr", w_addr, 0);
        check("t4_first_issue_cyc", c, 5);
        issue_seen = 1'b1;
      end
      if (m_valid) begin
        if (first_mv < 0) first_mv = c;
        mv_cnt++;
      end
      @(negedge clk);
    end
    check("t4_first_mv_cyc", first_mv, 12);
    check("t4_mv_count", mv_cnt, 4);

    // 5: M=1, N=1, MAC_LAT=1 gives a 4-cycle period: load, issue, drain, out.
    @(negedge clk);
    s2_valid = 1'b1;
    m2_ready = 1'b1;
    rst2_n   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #2;
      case (c % 4)
        0:       exp5 = 5'b11000;
        1:       exp5 = 5'b00110;
        2:       exp5 = 5'b00000;
        default: exp5 = 5'b00001;
      endcase
      check("t5_pattern", {s2_ready, x2_wr_en, acc2_en, acc2_clr, m2_valid}, exp5);
      if (acc2_en) check("t5_w_addr", w2_addr, 0);
      @(negedge clk);
    end

`ifdef LAYER_SEQ_CTRL_PERF_EN
    // 6: three vectors, 3 stall cycles on the first result and 4 on the last.
    reset_dut();
    #2;
    check("t6_rst_vec_cnt", vec_cnt, 0);
    check("t6_rst_stall_cnt", stall_cnt, 0);
    s_valid = 1'b1;
    cyc = 0; hs = 0; stall = 0;
    while (cyc < 300 && hs < 12) begin
      #1;
      m_ready = !(m_valid && ((hs == 0 && stall < 3) || (hs == 11 && stall < 7)));
      #1;
      if (!m_ready) stall++;
      if (m_valid && m_ready) hs++;
      cyc++;
      @(negedge clk);
      #0;
    end
    m_ready = 1'b1;
    s_valid = 1'b0;
    #2;
    check("t6_done", hs, 12);
    check("t6_vec_cnt", vec_cnt, 3);
    check("t6_stall_cnt", stall_cnt, 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
